sort_streamer: RTL
==================

SORT_STREAMER -- requirements
Module: sort_streamer

Interface
REQ-001 Parameter DATA_W, default 8, unsigned element width in bits.
REQ-002 Parameter DEPTH, default 8, elements per frame; legal values are even and >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_data carries a frame element.
REQ-006 in_data  input  DATA_W  unsigned frame element.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 out_valid  output  1  out_data carries a sorted element.
REQ-009 out_data  output  DATA_W  sorted element.
REQ-010 out_last  output  1  marks the final element of the sorted frame.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 busy  output  1  high in SORT and OUT states.

Function
REQ-013 FSM states SHALL be LOAD, SORT and OUT; the reset state is LOAD.
REQ-014 In LOAD, in_ready SHALL be 1, and each cycle with in_valid=1 SHALL write in_data into buffer slot cnt and increment cnt.
REQ-015 The accept that fills slot DEPTH-1 SHALL move the FSM to SORT on that edge and clear cnt.
REQ-016 SORT SHALL perform odd-even transposition, one phase per cycle: even phases compare pairs (0,1),(2,3)..., and odd phases compare pairs (1,2),(3,4)....
REQ-017 SORT SHALL run exactly DEPTH cycles, starting with an even phase, and then move to OUT.
REQ-018 A pair SHALL swap only when the ordering test is strictly violated, so equal values are never swapped.
REQ-019 In OUT, out_valid SHALL be 1, out_data SHALL equal buffer[cnt], and out_last SHALL be 1 only when cnt=DEPTH-1.
REQ-020 In OUT, cnt SHALL advance only on out_valid & out_ready; out_data SHALL be held stable while out_ready=0.
REQ-021 The handshake on the out_last element SHALL move the FSM to LOAD with cnt=0; in_ready SHALL rise on the next cycle, not the same cycle.
REQ-022 in_ready SHALL be 0 outside LOAD, and in_valid SHALL be ignored there.
REQ-023 out_valid and out_last SHALL be 0 outside OUT.
REQ-024 Latency: last input accepted at edge E SHALL produce out_valid=1 from edge E+DEPTH onward.
REQ-025 Comparison SHALL be unsigned over the full DATA_W bits.

Reset
REQ-026 rst_n=0 SHALL immediately force state=LOAD, cnt=0, in_ready=1, out_valid=0, out_last=0, busy=0 and out_data=0, independent of clk.
REQ-027 Buffer contents SHALL be cleared to 0 on reset.
REQ-028 Reset mid-LOAD, mid-SORT or mid-OUT SHALL discard the partial frame; the first accept after reset is slot 0.

Configuration
REQ-029 Macro SORT_STREAMER_DESCEND_EN SHALL select the sort direction at compile time.
REQ-030 When SORT_STREAMER_DESCEND_EN is undefined, the output SHALL be ascending: a pair swaps when left > right.
REQ-031 When SORT_STREAMER_DESCEND_EN is defined, the output SHALL be descending: a pair swaps when left < right.
REQ-032 Timing, latency and handshake behaviour SHALL be identical in both builds.

Verification
REQ-033 Ascending build, DEPTH=8, frame 1,2,12,8,4,10,6,3 with in_valid held high and out_ready=1 -> out_valid rises 8 cycles after the last accept; output is 1,2,3,4,6,8,10,12 on consecutive cycles; out_last is high only with 12.
REQ-034 Descending build, same frame -> output is 12,10,8,6,4,3,2,1; out_last is high only with 1.
REQ-035 Frame 255,0,7,7,255,0,128,7 with out_ready toggling every cycle -> output is 0,0,7,7,7,128,255,255; out_data is held stable during stalls; no element is lost or duplicated.
REQ-036 rst_n pulsed low during SORT of cycle 3 -> all outputs take their reset values immediately; the next frame 8,7,6,5,4,3,2,1 sorts to 1..8 correctly.
REQ-037 Two frames offered back-to-back with in_valid held high -> in_ready=0 from the 8th accept until the cycle after the out_last handshake; the second frame sorts correctly.
REQ-038 in_valid pulsed while busy=1 -> the input is not captured, and the frame in progress is output unchanged.

Source files
------------

// File: rtl/sort_streamer.sv
// Streaming frame sorter: loads DEPTH elements, sorts them by odd-even transposition, streams them out.
// Define SORT_STREAMER_DESCEND_EN for descending order; ascending when undefined.
module sort_streamer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // True when the pair must be exchanged; equal values never swap.
  function automatic logic out_of_order(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
`ifdef SORT_STREAMER_DESCEND_EN
    return l < r;
`else
    return l > r;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[cnt_q] = in_data;
          if (cnt_q == LAST_IDX) begin
            state_d = SORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SORT: begin
        // cnt doubles as the phase counter; its LSB selects even/odd pairing.
        for (int i = 0; i < DEPTH - 1; i++) begin
          if ((i % 2) == int'(cnt_q[0]) && out_of_order(mem_q[i], mem_q[i+1])) begin
            mem_d[i]   = mem_q[i+1];
            mem_d[i+1] = mem_q[i];
          end
        end
        if (cnt_q == LAST_IDX) begin
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign out_last  = (state_q == OUT) && (cnt_q == LAST_IDX);
  assign busy      = (state_q != LOAD);
  assign out_data  = mem_q[cnt_q];

endmodule
